// File: rtl/fb_scan_arbiter.sv
// fb_scan_arbiter: shares one single-port 12-bit framebuffer RAM between
// VGA scan-out reads, a valid/ready pixel writer and a clear engine.
// Scan-out reads always win. The clear engine comes next, and the writer
// gets whatever cycles remain.
// Optional feature macro FB_ARB_STALL_CNT_EN adds a stall_count[15:0] output.
// The counter counts writer stall cycles and is cleared by a rising vsync_in.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | normal operation, writer gets the non-read slots
// ST_CLEAR| filling the framebuffer with CLEAR_COLOR, writer blocked
module fb_scan_arbiter #(
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter int          SCALE_SHIFT = 2,
    parameter int          ADDR_W      = 15,
    parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pixel_tick,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              active_video,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [11:0]       wr_data,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              err_drop,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [11:0]       mem_wdata,
    input  logic [11:0]       mem_rdata,
    output logic              hsync,
    output logic              vsync,
    output logic [11:0]       rgb
`ifdef FB_ARB_STALL_CNT_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    localparam int FB_W     = H_ACTIVE >> SCALE_SHIFT;
    localparam int FB_H     = V_ACTIVE >> SCALE_SHIFT;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(FB_DEPTH);
    localparam logic [31:0]       FB_W_BITS = 32'(FB_W);

    typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              err_drop_q, err_drop_d;
    logic              tick_s1_q, tick_s1_d;
    logic              active_s1_q, active_s1_d;
    logic              hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;
    logic              hsync_q, hsync_d, vsync_q, vsync_d;
    logic [11:0]       rgb_q, rgb_d;
    logic [9:0]        fb_x, fb_y;
    logic [ADDR_W-1:0] rd_addr;
    logic              read_slot;

    // Scan-out address: row * FB_W + column, built from shifted copies of the row.
    always_comb begin
        fb_x    = x >> SCALE_SHIFT;
        fb_y    = y >> SCALE_SHIFT;
        rd_addr = ADDR_W'(fb_x);
        for (int i = 0; i < ADDR_W; i++) begin
            if (FB_W_BITS[i]) rd_addr = rd_addr + (ADDR_W'(fb_y) << i);
        end
    end

    // Slot decision, memory port, handshake and clear FSM next state.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        err_drop_d = 1'b0;
        wr_ready   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        read_slot  = pixel_tick & active_video;
        if (!reset) begin
            if (read_slot) begin
                mem_en   = 1'b1;
                mem_addr = rd_addr;
            end else if (state_q == ST_CLEAR) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = ptr_q;
                mem_wdata = CLEAR_COLOR;
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end else if (wr_valid) begin
                wr_ready = 1'b1;
                if (wr_addr < DEPTH_A) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = wr_addr;
                    mem_wdata = wr_data;
                end else begin
                    err_drop_d = 1'b1;
                end
            end
            if (state_q == ST_IDLE && clear_req) begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        end
    end

    // Two-stage scan-out pipeline keeping syncs aligned with rgb.
    always_comb begin
        tick_s1_d   = pixel_tick;
        active_s1_d = active_video;
        hs_s1_d     = hsync_in;
        vs_s1_d     = vsync_in;
        hsync_d     = hs_s1_q;
        vsync_d     = vs_s1_q;
        rgb_d       = rgb_q;
        if (tick_s1_q) rgb_d = active_s1_q ? mem_rdata : 12'h000;
    end

    // State and pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            err_drop_q  <= 1'b0;
            tick_s1_q   <= 1'b0;
            active_s1_q <= 1'b0;
            hs_s1_q     <= 1'b0;
            vs_s1_q     <= 1'b0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            rgb_q       <= 12'h000;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            err_drop_q  <= err_drop_d;
            tick_s1_q   <= tick_s1_d;
            active_s1_q <= active_s1_d;
            hs_s1_q     <= hs_s1_d;
            vs_s1_q     <= vs_s1_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            rgb_q       <= rgb_d;
        end
    end

    assign clear_busy = (state_q == ST_CLEAR);
    assign err_drop   = err_drop_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign rgb        = rgb_q;

`ifdef FB_ARB_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Writer stall counter, saturating; a new frame (vsync_in rising) restarts it.
    always_comb begin
        stall_d = stall_q;
        if (vsync_in && !vs_s1_q)               stall_d = 16'h0000;
        else if (wr_valid && !wr_ready && stall_q != 16'hFFFF) stall_d = stall_q + 16'h0001;
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_q <= 16'h0000;
        else       stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Directed self-checking bench for fb_scan_arbiter with a simple RAM model
// that returns 12'hABC on every read.
module tb_fb_scan_arbiter;

    localparam int DEPTH = 19200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pixel_tick = 1'b0;
    logic [9:0]  x = '0, y = '0;
    logic        active_video = 1'b0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [14:0] wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic        clear_req = 1'b0;
    logic        clear_busy, err_drop;
    logic        mem_en, mem_we;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata = 12'h000;
    logic        hsync, vsync;
    logic [11:0] rgb;
`ifdef FB_ARB_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    int tests = 0;
    int fails = 0;

    fb_scan_arbiter dut (
        .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .x(x), .y(y),
        .active_video(active_video), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear_req(clear_req), .clear_busy(clear_busy), .err_drop(err_drop),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .hsync(hsync), .vsync(vsync), .rgb(rgb)
`ifdef FB_ARB_STALL_CNT_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    // RAM model: read data appears one clk after the read.
    always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= 12'hABC;

    // Write monitor.
    bit seen [DEPTH];
    int clear_writes = 0, clear_dups = 0, clear_bad = 0, ready_in_clear = 0;
    int writes_5 = 0;
    logic track_clear = 1'b0;
    logic busy_after_last = 1'b1;
    always @(posedge clk) begin
        if (!reset && mem_en && mem_we && mem_addr == 15'd5 && mem_wdata == 12'hF00) writes_5++;
        if (track_clear && clear_busy && wr_ready) ready_in_clear++;
        if (track_clear && clear_busy && mem_en && mem_we) begin
            if (mem_wdata !== 12'h000 || mem_addr >= 15'(DEPTH)) clear_bad++;
            else begin
                if (seen[mem_addr]) clear_dups++;
                seen[mem_addr] = 1'b1;
                clear_writes++;
                if (mem_addr == 15'(DEPTH - 1)) begin
                    #1 busy_after_last = clear_busy;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        int missing;
        // Reset mid-frame
        x = 10'd100; y = 10'd50; active_video = 1'b1; pixel_tick = 1'b1; wr_valid = 1'b1;
        hsync_in = 1'b1; vsync_in = 1'b1;
        #1;
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_busy", 32'(clear_busy), 0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        repeat (3) step();
        chk("rst_hold_hsync", 32'(hsync), 0);
        chk("rst_hold_mem_addr", 32'(mem_addr), 0);
        chk("rst_hold_err", 32'(err_drop), 0);
        pixel_tick = 1'b0; active_video = 1'b0; wr_valid = 1'b0;
        hsync_in = 1'b0; vsync_in = 1'b0;
        reset = 1'b0;
        step();

        // Read address at last pixel
        x = 10'd639; y = 10'd479; active_video = 1'b1; pixel_tick = 1'b1;
        hsync_in = 1'b1; vsync_in = 1'b1;
        #1;
        chk("rd_mem_en", 32'(mem_en), 1);
        chk("rd_mem_we", 32'(mem_we), 0);
        chk("rd_mem_addr", 32'(mem_addr), 19199);
        step();
        pixel_tick = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        #1;
        chk("rd_hsync_lag1", 32'(hsync), 0);
        step();
        chk("rd_rgb", 32'(rgb), 12'hABC);
        chk("rd_hsync_lag2", 32'(hsync), 1);
        chk("rd_vsync_lag2", 32'(vsync), 1);
        step();
        chk("rd_hsync_fall", 32'(hsync), 0);
        chk("rd_rgb_hold", 32'(rgb), 12'hABC);

        // Another address: x=17, y=9 -> row 2, col 4 -> 324
        x = 10'd17; y = 10'd9; pixel_tick = 1'b1;
        #1 chk("rd_addr_324", 32'(mem_addr), 324);
        step();
        pixel_tick = 1'b0;

        // Blanking tick clears rgb
        active_video = 1'b0; pixel_tick = 1'b1;
        #1 chk("blank_no_read", 32'(mem_en), 0);
        step();
        pixel_tick = 1'b0;
        step();
        chk("blank_rgb_zero", 32'(rgb), 0);

        // Collision with READ slot
        x = 10'd0; y = 10'd0; active_video = 1'b1; pixel_tick = 1'b1;
        wr_valid = 1'b1; wr_addr = 15'd5; wr_data = 12'hF00;
        #1;
        chk("col_ready_read", 32'(wr_ready), 0);
        chk("col_we_read", 32'(mem_we), 0);
        step();
        pixel_tick = 1'b0;
        #1;
        chk("col_ready_next", 32'(wr_ready), 1);
        chk("col_mem_addr", 32'(mem_addr), 5);
        chk("col_mem_wdata", 32'(mem_wdata), 12'hF00);
        step();
        wr_valid = 1'b0;
        step();
        chk("col_one_write", 32'(writes_5), 1);

        // Out of range write during blanking
        active_video = 1'b0;
        wr_valid = 1'b1; wr_addr = 15'd19200; wr_data = 12'h0F0;
        #1;
        chk("oor_ready", 32'(wr_ready), 1);
        chk("oor_mem_en", 32'(mem_en), 0);
        chk("oor_err_now", 32'(err_drop), 0);
        step();
        wr_valid = 1'b0;
        #1 chk("oor_err_pulse", 32'(err_drop), 1);
        step();
        chk("oor_err_end", 32'(err_drop), 0);

        // Clear during active scan, clear_req together with a pending write
        track_clear = 1'b1;
        wr_valid = 1'b1; wr_addr = 15'd7; wr_data = 12'h555; clear_req = 1'b1;
        #1;
        chk("clr_same_clk_ready", 32'(wr_ready), 1);
        chk("clr_same_clk_busy", 32'(clear_busy), 0);
        step();
        clear_req = 1'b0;
        #1;
        chk("clr_busy", 32'(clear_busy), 1);
        chk("clr_ready_low", 32'(wr_ready), 0);
        active_video = 1'b1;
        cyc = 0;
        while (clear_busy && cyc < 40000) begin
            pixel_tick = (cyc % 4 == 0);
            x = 10'((cyc / 4) % 640);
            y = 10'((cyc / 2560) % 480);
            clear_req = (cyc == 5000);
            step();
            cyc++;
        end
        pixel_tick = 1'b0; clear_req = 1'b0; active_video = 1'b0;
        chk("clr_done_in_budget", 32'(clear_busy), 0);
        track_clear = 1'b0;
        missing = 0;
        for (int i = 0; i < DEPTH; i++) if (!seen[i]) missing++;
        chk("clr_write_count", 32'(clear_writes), DEPTH);
        chk("clr_missing", 32'(missing), 0);
        chk("clr_dups", 32'(clear_dups), 0);
        chk("clr_bad_writes", 32'(clear_bad), 0);
        chk("clr_ready_during", 32'(ready_in_clear), 0);
        chk("clr_busy_after_last", 32'(busy_after_last), 0);
        #1 chk("clr_writer_resumes", 32'(wr_ready), 1);
        step();
        wr_valid = 1'b0;

        // Reset during clear aborts it
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (20) step();
        chk("abort_busy_before", 32'(clear_busy), 1);
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(clear_busy), 0);
        chk("abort_mem_en", 32'(mem_en), 0);
        step();
        reset = 1'b0;
        step();
        chk("abort_stays_idle", 32'(clear_busy), 0);
        chk("abort_mem_idle", 32'(mem_en), 0);

`ifdef FB_ARB_STALL_CNT_EN
        // Stall counter
        vsync_in = 1'b0;
        step();
        vsync_in = 1'b1;
        step();
        chk("stall_cleared", 32'(stall_count), 0);
        active_video = 1'b1; pixel_tick = 1'b1; wr_valid = 1'b1; wr_addr = 15'd9;
        repeat (10) step();
        pixel_tick = 1'b0; wr_valid = 1'b0; active_video = 1'b0;
        step();
        chk("stall_ten", 32'(stall_count), 10);
        vsync_in = 1'b0;
        step();
        chk("stall_hold", 32'(stall_count), 10);
        vsync_in = 1'b1;
        step();
        chk("stall_vsync_clear", 32'(stall_count), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
